line_ram_writer: RTL and testbench

// - Consumer end of the Maria DMA byte stream: takes fetched graphic bytes (latch_byte/DataB)

---
 rtl/maria_pkg.sv | 54 +++++
 rtl/line_ram_bank.sv | 22 ++
 rtl/line_ram_writer.sv | 198 +++++++++++++++++++
 tb/tb_line_ram_writer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maria_pkg.sv
// Shared Maria line-RAM types and constants, used by the DMA controller, the line RAM writer
// and the video readout.
package maria_pkg;

   localparam int unsigned CELLS      = 160;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CELL_W     = 5;

   typedef enum logic {
      WM_160A = 1'b0,
      WM_160B = 1'b1
   } wm_t;

   typedef struct packed {
      logic [2:0] pal;
      logic [1:0] col;
   } lr_cell_t;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] pal;
      wm_t        wm;
      logic [7:0] base;
   } fifo_entry_t;

   typedef enum logic [1:0] {
      StIdle,
      StPop,
      StPix
   } unpack_state_t;

   function automatic logic in_line(input logic [7:0] addr);
      return addr < 8'(CELLS);
   endfunction

   // Pixel k of a graphic byte; 160B borrows the upper data bits as palette bits.
   function automatic lr_cell_t unpack_px(input logic [7:0] d, input logic [2:0] pal,
                                          input wm_t wm, input logic [1:0] k);
      lr_cell_t c;
      c.pal = pal;
      case (k)
         2'd0:    c.col = d[7:6];
         2'd1:    c.col = d[5:4];
         2'd2:    c.col = d[3:2];
         default: c.col = d[1:0];
      endcase
      if (wm == WM_160B) begin
         c.col = k[0] ? d[1:0] : d[3:2];
         c.pal = {pal[2], (k[0] ? d[5:4] : d[7:6])};
      end
      return c;
   endfunction

endpackage

// File: rtl/line_ram_bank.sv
// One bank of the line RAM: simple dual-port storage with a registered read port.
module line_ram_bank #(
   parameter int unsigned CELLS  = 160,
   parameter int unsigned CELL_W = 5
) (
   input  logic              clk_sys,
   input  logic              we,
   input  logic [7:0]        waddr,
   input  logic [CELL_W-1:0] wdata,
   input  logic              re,
   input  logic [7:0]        raddr,
   output logic [CELL_W-1:0] rdata
);

   logic [CELL_W-1:0] mem [CELLS];

   always_ff @(posedge clk_sys) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/line_ram_writer.sv
// Unpacks DMA graphic bytes into the write bank of a double-buffered line RAM while the
// display bank is read out and cleared behind the video path.
module line_ram_writer
   import maria_pkg::*;
(
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              mclk0,
   input  logic              latch_byte,
   input  logic [7:0]        DataB,
   input  logic              clear_hpos,
   input  logic [7:0]        HPOS,
   input  logic [2:0]        PAL,
   input  logic              WM,
   input  logic              kangaroo,
   input  logic              lrc,
   input  logic              rd_en,
   input  logic [7:0]        rd_addr,
   output logic [CELL_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              ovf,
   output logic              disp_bank
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic              disp_bank_q, arm_q, ptr_ok_q, ovf_q;
   logic [7:0]        wptr_q;
   logic [2:0]        pal_q;
   wm_t               wm_q;
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;
   fifo_entry_t       fifo_q [FIFO_DEPTH];

   unpack_state_t     state_q, state_d;
   logic [1:0]        k_q, k_d;
   fifo_entry_t       cur_q, cur_d;

   logic              rd_valid_q, rd_ok_q, rd_bank_q;
   logic [7:0]        rd_addr_q;

   logic swap, push_req, fifo_full, push, pop, px_we, last_px, px_write, rd_ok, clr_we;
   logic [7:0]        px_addr;
   lr_cell_t          px_cell, rdata0, rdata1;

   // Swap ends the line: anything captured in the same cycle belongs to a dead line.
   assign swap      = mclk0 & lrc;
   assign push_req  = mclk0 & latch_byte & ptr_ok_q & ~swap;
   assign fifo_full = (count_q == CntW'(FIFO_DEPTH));
   assign push      = push_req & ~fifo_full;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         disp_bank_q <= 1'b0;
         arm_q       <= 1'b0;
         ptr_ok_q    <= 1'b0;
         ovf_q       <= 1'b0;
         wptr_q      <= '0;
         pal_q       <= '0;
         wm_q        <= WM_160A;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else if (swap) begin
         disp_bank_q <= ~disp_bank_q;
         arm_q       <= 1'b0;
         ptr_ok_q    <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         if (mclk0 && clear_hpos) begin
            arm_q <= 1'b1;
         end else if (mclk0 && arm_q) begin
            arm_q    <= 1'b0;
            ptr_ok_q <= 1'b1;
            pal_q    <= PAL;
            wm_q     <= wm_t'(WM);
         end
         // A new HPOS takes precedence; a byte pushed alongside it used the old pointer.
         if (mclk0 && !clear_hpos && arm_q) begin
            wptr_q <= HPOS;
         end else if (push_req) begin
            wptr_q <= wptr_q + ((wm_q == WM_160B) ? 8'd2 : 8'd4);
         end
         if (push_req && fifo_full) ovf_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) fifo_q[wr_ptr_q] <= '{data: DataB, pal: pal_q, wm: wm_q, base: wptr_q};
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         k_q     <= '0;
         cur_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cur_q   <= cur_d;
      end
   end

   assign last_px = (cur_q.wm == WM_160B) ? (k_q == 2'd1) : (k_q == 2'd3);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cur_d   = cur_q;
      pop     = 1'b0;
      px_we   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) state_d = StPop;
         end
         StPop: begin
            pop     = 1'b1;
            cur_d   = fifo_q[rd_ptr_q];
            k_d     = 2'd0;
            state_d = StPix;
         end
         StPix: begin
            px_we = 1'b1;
            k_d   = k_q + 2'd1;
            if (last_px) state_d = (count_q != '0) ? StPop : StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (swap) begin
         state_d = StIdle;
         pop     = 1'b0;
         px_we   = 1'b0;
      end
   end

   assign px_addr  = cur_q.base + {6'd0, k_q};
   assign px_cell  = unpack_px(cur_q.data, cur_q.pal, cur_q.wm, k_q);
   assign px_write = px_we & in_line(px_addr) & ((px_cell.col != 2'b00) | kangaroo);

   assign rd_ok = rd_en & in_line(rd_addr);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_ok_q    <= 1'b0;
         rd_bank_q  <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         rd_valid_q <= rd_en;
         rd_ok_q    <= rd_ok;
         rd_bank_q  <= disp_bank_q;
         rd_addr_q  <= rd_addr;
      end
   end

   // Clear only if the bank read is still the display bank after a possible swap.
   assign clr_we = rd_ok_q & (rd_bank_q == disp_bank_q);

   line_ram_bank #(
      .CELLS  (CELLS),
      .CELL_W (CELL_W)
   ) u_bank0 (
      .clk_sys (clk_sys),
      .we      (disp_bank_q ? px_write : clr_we),
      .waddr   (disp_bank_q ? px_addr : rd_addr_q),
      .wdata   (disp_bank_q ? px_cell : lr_cell_t'('0)),
      .re      (rd_ok & ~disp_bank_q),
      .raddr   (rd_addr),
      .rdata   (rdata0)
   );

   line_ram_bank #(
      .CELLS  (CELLS),
      .CELL_W (CELL_W)
   ) u_bank1 (
      .clk_sys (clk_sys),
      .we      (disp_bank_q ? clr_we : px_write),
      .waddr   (disp_bank_q ? rd_addr_q : px_addr),
      .wdata   (disp_bank_q ? lr_cell_t'('0) : px_cell),
      .re      (rd_ok & disp_bank_q),
      .raddr   (rd_addr),
      .rdata   (rdata1)
   );

   assign rd_data   = rd_ok_q ? (rd_bank_q ? rdata1 : rdata0) : '0;
   assign rd_valid  = rd_valid_q;
   assign busy      = (count_q != '0) | (state_q != StIdle);
   assign ovf       = ovf_q;
   assign disp_bank = disp_bank_q;

endmodule

// File: tb/tb_line_ram_writer.sv
// Directed bench for line_ram_writer: stimulus queues expected read data, a monitor checks it.
module tb_line_ram_writer;

   logic       clk_sys = 1'b0;
   logic       reset_n, mclk0, latch_byte, clear_hpos, WM, kangaroo, lrc, rd_en;
   logic [7:0] DataB, HPOS, rd_addr;
   logic [2:0] PAL;
   logic [4:0] rd_data;
   logic       rd_valid, busy, ovf, disp_bank;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [4:0] exp_q [$];
   string      name_q [$];
   bit         ignore_rd = 1'b0;

   always #5 clk_sys = ~clk_sys;

   line_ram_writer dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .mclk0      (mclk0),
      .latch_byte (latch_byte),
      .DataB      (DataB),
      .clear_hpos (clear_hpos),
      .HPOS       (HPOS),
      .PAL        (PAL),
      .WM         (WM),
      .kangaroo   (kangaroo),
      .lrc        (lrc),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .ovf        (ovf),
      .disp_bank  (disp_bank)
   );

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: every read strobe consumes one expected cell value.
   always @(negedge clk_sys) begin : monitor
      logic [4:0] e;
      string      nm;
      if (reset_n && rd_valid && !ignore_rd) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_unexpected: got 0x%0h, expected no read", rd_data);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, {3'd0, rd_data}, {3'd0, e});
         end
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_sys);
   endtask

   task automatic rd(input logic [7:0] a, input logic [4:0] e, input string nm);
      if (!ignore_rd) begin
         exp_q.push_back(e);
         name_q.push_back($sformatf("%s[%0d]", nm, a));
      end
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic rd4(input logic [7:0] a, input logic [4:0] e0, input logic [4:0] e1,
                      input logic [4:0] e2, input logic [4:0] e3, input string nm);
      rd(a, e0, nm);
      rd(a + 8'd1, e1, nm);
      rd(a + 8'd2, e2, nm);
      rd(a + 8'd3, e3, nm);
   endtask

   task automatic do_lrc();
      lrc = 1'b1;
      tick();
      lrc = 1'b0;
   endtask

   task automatic load_hpos(input logic [7:0] h, input logic [2:0] p, input logic w);
      clear_hpos = 1'b1;
      HPOS = h;
      PAL  = p;
      WM   = w;
      tick();
      clear_hpos = 1'b0;
      tick();
   endtask

   task automatic send(input logic [7:0] d);
      latch_byte = 1'b1;
      DataB      = d;
      tick();
      latch_byte = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int i = 0;
      while (busy && i < 20) begin
         tick();
         i++;
      end
      check(nm, {7'd0, busy}, 8'd0);
   endtask

   task automatic clear_disp_bank();
      ignore_rd = 1'b1;
      for (int a = 0; a < 160; a++) rd(8'(a), 5'd0, "clr");
      tick();
      tick();
      ignore_rd = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;  mclk0 = 1'b1;  latch_byte = 1'b0;  clear_hpos = 1'b0;
      WM = 1'b0;  kangaroo = 1'b0;  lrc = 1'b0;  rd_en = 1'b0;
      DataB = '0;  HPOS = '0;  PAL = '0;  rd_addr = '0;
      sample();
      sample();
      check("reset_rd_data", {3'd0, rd_data}, 8'd0);
      check("reset_rd_valid", {7'd0, rd_valid}, 8'd0);
      check("reset_busy", {7'd0, busy}, 8'd0);
      check("reset_ovf", {7'd0, ovf}, 8'd0);
      check("reset_disp_bank", {7'd0, disp_bank}, 8'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // No HPOS loaded yet: byte must be ignored.
      send(8'hFF);
      sample();
      check("no_ptr_ignored", {7'd0, busy}, 8'd0);

      tick();
      do_lrc();
      clear_disp_bank();
      do_lrc();
      clear_disp_bank();
      sample();
      check("init_disp_bank", {7'd0, disp_bank}, 8'd0);

      // 160A transparent: cell 10 untouched.
      tick();
      load_hpos(8'd10, 3'd3, 1'b0);
      send(8'h1B);
      wait_idle("a_idle");
      do_lrc();
      sample();
      check("a_disp_bank", {7'd0, disp_bank}, 8'd1);
      tick();
      rd(8'd9, 5'h00, "a");
      rd4(8'd10, 5'h00, 5'h0D, 5'h0E, 5'h0F, "a");
      rd(8'd14, 5'h00, "a");
      rd4(8'd10, 5'h00, 5'h00, 5'h00, 5'h00, "a_cleared");
      rd(8'd200, 5'h00, "a_oob");

      // Kangaroo mode writes colour 00.
      kangaroo = 1'b1;
      load_hpos(8'd10, 3'd3, 1'b0);
      send(8'h1B);
      wait_idle("b_idle");
      kangaroo = 1'b0;
      do_lrc();
      rd4(8'd10, 5'h0C, 5'h0D, 5'h0E, 5'h0F, "b");
      rd4(8'd10, 5'h00, 5'h00, 5'h00, 5'h00, "b_cleared");

      // 160B: data bits feed palette; pointer advances by 2.
      load_hpos(8'd20, 3'd4, 1'b1);
      send(8'hE4);
      send(8'h1B);
      wait_idle("c_idle");
      do_lrc();
      rd4(8'd20, 5'h1D, 5'h00, 5'h12, 5'h17, "c");

      // Right-edge skip, 8-bit wrap, and last object wins on overlap.
      load_hpos(8'd158, 3'd2, 1'b0);
      send(8'hFF);
      wait_idle("d_idle0");
      load_hpos(8'd254, 3'd1, 1'b0);
      send(8'hFF);
      send(8'hFF);
      wait_idle("d_idle1");
      load_hpos(8'd3, 3'd6, 1'b0);
      send(8'h40);
      wait_idle("d_idle2");
      sample();
      check("d_ovf_clear", {7'd0, ovf}, 8'd0);
      tick();
      do_lrc();
      rd4(8'd156, 5'h00, 5'h00, 5'h0B, 5'h0B, "d");
      rd4(8'd0, 5'h07, 5'h07, 5'h07, 5'h19, "d");
      rd4(8'd4, 5'h07, 5'h07, 5'h00, 5'h00, "d");

      // Three back-to-back bytes into a 2-deep FIFO: third dropped.
      load_hpos(8'd30, 3'd0, 1'b0);
      latch_byte = 1'b1;
      DataB = 8'h55;
      tick();
      DataB = 8'hAA;
      tick();
      DataB = 8'hFF;
      tick();
      latch_byte = 1'b0;
      sample();
      check("e_ovf_set", {7'd0, ovf}, 8'd1);
      check("e_busy_held", {7'd0, busy}, 8'd1);
      tick();
      wait_idle("e_idle");
      do_lrc();
      sample();
      check("e_ovf_sticky", {7'd0, ovf}, 8'd1);
      tick();
      rd4(8'd30, 5'h01, 5'h01, 5'h01, 5'h01, "e");
      rd4(8'd34, 5'h02, 5'h02, 5'h02, 5'h02, "e");
      rd4(8'd38, 5'h00, 5'h00, 5'h00, 5'h00, "e_dropped");

      // mclk0 low masks capture; lrc mid-unpack aborts the rest and wins over latch_byte.
      load_hpos(8'd40, 3'd7, 1'b0);
      mclk0 = 1'b0;
      send(8'hFF);
      mclk0 = 1'b1;
      sample();
      check("f_mclk0_gate", {7'd0, busy}, 8'd0);
      tick();
      send(8'hFF);
      tick();
      tick();
      tick();
      tick();
      latch_byte = 1'b1;
      DataB = 8'h00;
      do_lrc();
      latch_byte = 1'b0;
      sample();
      check("f_busy_after_lrc", {7'd0, busy}, 8'd0);
      check("f_disp_bank", {7'd0, disp_bank}, 8'd0);
      tick();
      send(8'hFF);
      sample();
      check("f_ptr_cleared", {7'd0, busy}, 8'd0);
      tick();
      rd4(8'd40, 5'h1F, 5'h1F, 5'h00, 5'h00, "f");

      // Reset in the middle of a line.
      tick();
      tick();
      load_hpos(8'd50, 3'd1, 1'b0);
      send(8'hFF);
      rd_en   = 1'b1;
      rd_addr = 8'd40;
      #1;
      reset_n = 1'b0;
      sample();
      check("g_rd_data", {3'd0, rd_data}, 8'd0);
      check("g_rd_valid", {7'd0, rd_valid}, 8'd0);
      check("g_busy", {7'd0, busy}, 8'd0);
      check("g_ovf", {7'd0, ovf}, 8'd0);
      check("g_disp_bank", {7'd0, disp_bank}, 8'd0);
      rd_en = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      check("reads_drained", 8'(exp_q.size()), 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
